pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch sequencer.
//
// It holds the current PC and drives it to the external PC+4 adder and to
// instruction memory. The adder result comes back on pc_next and becomes the
// sequential next PC once decode consumes the held instruction. Redirects
// (branch/jump) are accepted in any state. A fetch that is in flight when a
// redirect arrives completes on the bus, but its data is thrown away.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous, active-high reset
//   pc_addr         out  current PC (adder input and imem address)
//   pc_next         in   pc_addr + 4 from the external adder
//   imem_req        out  fetch request, address = pc_addr
//   imem_ack        in   fetch completion, imem_rdata valid this cycle
//   imem_rdata      in   fetched instruction word
//   redirect_valid  in   branch/jump taken this cycle
//   redirect_target in   new PC for the redirect (low two bits ignored)
//   instr           out  held instruction
//   instr_pc        out  PC of the held instruction
//   instr_valid     out  instr/instr_pc valid
//   instr_ready     in   decode accepts instr this cycle
module pc_fetch_ctrl #(
  parameter int                           instruction_width = 32,
  parameter logic [instruction_width-1:0] RESET_VECTOR      = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [instruction_width-1:0] pc_addr,
  input  logic [instruction_width-1:0] pc_next,
  output logic                         imem_req,
  input  logic                         imem_ack,
  input  logic [instruction_width-1:0] imem_rdata,
  input  logic                         redirect_valid,
  input  logic [instruction_width-1:0] redirect_target,
  output logic [instruction_width-1:0] instr,
  output logic [instruction_width-1:0] instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready
);

  localparam int W = instruction_width;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_pc;
  logic [W-1:0]   w_pc_nxt;
  logic           r_req;
  logic           w_req_nxt;
  logic [W-1:0]   r_instr;
  logic [W-1:0]   w_instr_nxt;
  logic [W-1:0]   r_instr_pc;
  logic [W-1:0]   w_instr_pc_nxt;
  logic           r_vld;
  logic           w_vld_nxt;
  logic           r_kill;
  logic           w_kill_nxt;
  logic [W-1:0]   r_pend_pc;
  logic [W-1:0]   w_pend_pc_nxt;

  logic           w_ack;
  logic [W-1:0]   w_tgt;

  function automatic logic [W-1:0] align_pc(input logic [W-1:0] addr);
    return {addr[W-1:2], 2'b00};
  endfunction

  // An ack with no request outstanding (e.g. a late one after reset) is noise.
  assign w_ack = imem_ack & r_req;
  assign w_tgt = align_pc(redirect_target);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_nxt      = r_req;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_vld_nxt      = r_vld;
    w_kill_nxt     = r_kill;
    w_pend_pc_nxt  = r_pend_pc;

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_WAIT;
        w_req_nxt   = 1'b1;
        if (redirect_valid) w_pc_nxt = w_tgt;
      end

      S_WAIT: begin
        if (w_ack) begin
          w_req_nxt = 1'b0;
          if (r_kill || redirect_valid) begin
            // A redirect in the ack cycle is newer than any parked target.
            w_pc_nxt    = redirect_valid ? w_tgt : r_pend_pc;
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_instr_nxt    = imem_rdata;
            w_instr_pc_nxt = r_pc;
            w_vld_nxt      = 1'b1;
            w_state_nxt    = S_HOLD;
          end
        end else if (redirect_valid) begin
          // pc_addr must stay stable while the request is up, so the target
          // is parked until the in-flight fetch drains.
          w_kill_nxt    = 1'b1;
          w_pend_pc_nxt = w_tgt;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          w_vld_nxt   = 1'b0;
          w_pc_nxt    = w_tgt;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (instr_ready) begin
          w_vld_nxt   = 1'b0;
          w_pc_nxt    = pc_next;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_vld_nxt   = 1'b0;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_req      <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_vld      <= 1'b0;
      r_kill     <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req      <= w_req_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_vld      <= w_vld_nxt;
      r_kill     <= w_kill_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end

  assign pc_addr     = r_pc;
  assign imem_req    = r_req;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_vld;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] D1 = 32'h2002_0005;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_addr, pc_next, imem_rdata, redirect_target, instr, instr_pc;
  logic         imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External PC+4 adder
  assign pc_next = pc_addr + 32'd4;

  pc_fetch_ctrl #(.instruction_width(W), .RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_addr         (pc_addr),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready)
  );

  // Reference model, in fetch-transaction terms:
  //   m_busy  : a fetch is outstanding on the bus
  //   m_have  : an instruction is offered to decode
  //   neither : the mandatory one-cycle gap between fetches
  logic [31:0] m_pc, m_instr, m_ipc, m_redir_pc;
  logic        m_busy, m_have, m_stale;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = RV; m_busy = 0; m_have = 0; m_instr = 0; m_ipc = 0;
      m_stale = 0; m_redir_pc = 0;
    end else if (m_busy) begin
      if (imem_ack) begin
        m_busy = 0;
        if (m_stale || redirect_valid) begin
          m_pc    = redirect_valid ? word_of(redirect_target) : m_redir_pc;
          m_stale = 0;
        end else begin
          m_have  = 1;
          m_instr = imem_rdata;
          m_ipc   = m_pc;
        end
      end else if (redirect_valid) begin
        m_stale    = 1;
        m_redir_pc = word_of(redirect_target);
      end
    end else if (m_have) begin
      if (redirect_valid || instr_ready) begin
        m_have = 0;
        m_busy = 1;
        m_pc   = redirect_valid ? word_of(redirect_target) : m_pc + 32'd4;
      end
    end else begin
      m_busy = 1;
      if (redirect_valid) m_pc = word_of(redirect_target);
    end
  endtask

  task automatic drv(input logic r, input logic a, input logic [31:0] d,
                     input logic rv, input logic [31:0] rt, input logic rdy);
    rst = r; imem_ack = a; imem_rdata = d;
    redirect_valid = rv; redirect_target = rt; instr_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("pc_addr", pc_addr, m_pc);
    check_eq("imem_req", 32'(imem_req), 32'(m_busy));
    check_eq("instr_valid", 32'(instr_valid), 32'(m_have));
    check_eq("instr", instr, m_instr);
    check_eq("instr_pc", instr_pc, m_ipc);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0);
    m_pc = 0; m_busy = 0; m_have = 0; m_instr = 0; m_ipc = 0; m_stale = 0; m_redir_pc = 0;
    tick(); tick();
    check_eq("rst_pc", pc_addr, RV);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_vld", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'd0);

    // 1: sequential fetch 0,4,8,C
    drv(0, 0, 0, 0, 0, 1); tick();
    check_eq("t1_req_rise", 32'(imem_req), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq("t1_fetch_pc", pc_addr, 32'(k * 4));
      drv(0, 0, 0, 0, 0, 1); tick();
      drv(0, 1, D1, 0, 0, 1); tick();
      check_eq("t1_instr", instr, D1);
      check_eq("t1_instr_pc", instr_pc, 32'(k * 4));
      check_eq("t1_vld", 32'(instr_valid), 32'd1);
      drv(0, 0, 0, 0, 0, 1); tick();
    end

    // 2: stall in hold for 5 cycles
    drv(0, 1, 32'hDEAD_0001, 0, 0, 0); tick();
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 0, 0, 0, 0); tick();
      check_eq("t2_pc", pc_addr, 32'h10);
      check_eq("t2_ipc", instr_pc, 32'h10);
      check_eq("t2_instr", instr, 32'hDEAD_0001);
      check_eq("t2_req", 32'(imem_req), 32'd0);
    end
    drv(0, 0, 0, 0, 0, 1); tick();
    check_eq("t2_next_pc", pc_addr, 32'h14);

    // 3: redirect during wait, ack 3 cycles later
    drv(0, 0, 0, 1, 32'h0000_0103, 0); tick();
    drv(0, 0, 0, 0, 0, 0); tick();
    check_eq("t3_pc_stable", pc_addr, 32'h14);
    tick();
    drv(0, 1, 32'hBAD0_BAD0, 0, 0, 0); tick();
    check_eq("t3_no_vld", 32'(instr_valid), 32'd0);
    drv(0, 0, 0, 0, 0, 0); tick();
    check_eq("t3_req", 32'(imem_req), 32'd1);
    check_eq("t3_pc", pc_addr, 32'h100);

    // 4: two redirects then a third in the ack cycle
    drv(0, 0, 0, 1, 32'h40, 0); tick();
    drv(0, 0, 0, 1, 32'h80, 0); tick();
    drv(0, 1, 32'hBAD1_BAD1, 1, 32'hC0, 0); tick();
    check_eq("t4_no_vld", 32'(instr_valid), 32'd0);
    drv(0, 0, 0, 0, 0, 0); tick();
    check_eq("t4_pc", pc_addr, 32'hC0);

    // 5: redirect and ready together in hold
    drv(0, 1, 32'h1234_5678, 0, 0, 0); tick();
    check_eq("t5_vld", 32'(instr_valid), 32'd1);
    drv(0, 0, 0, 1, 32'h200, 1); tick();
    check_eq("t5_vld_drop", 32'(instr_valid), 32'd0);
    check_eq("t5_pc", pc_addr, 32'h200);

    // 6: reset while waiting, ack arrives right after
    drv(1, 0, 0, 0, 0, 0); tick();
    check_eq("t6_pc", pc_addr, RV);
    drv(0, 1, 32'hBAD2_BAD2, 0, 0, 0); tick();
    check_eq("t6_vld", 32'(instr_valid), 32'd0);
    check_eq("t6_req", 32'(imem_req), 32'd1);
    drv(0, 1, D1, 0, 0, 1); tick();
    check_eq("t6_ipc", instr_pc, RV);
    drv(0, 0, 0, 0, 0, 1); tick();
    check_eq("t6_next", pc_addr, RV + 32'd4);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 2) == 0),
          $urandom(),
          ($urandom_range(0, 7) == 0),
          $urandom(),
          ($urandom_range(0, 1) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
